dsp_simd2x_unpack_uint8: RTL

Consumer end of the 2x INT9xUINT8 SIMD DSP packing scheme. The final P output of a DSP cascade carries two accumulated products in one 48-bit word: lane A in P[17:0] and lane B from P[18] upward. This block splits the word into two signed sums and removes the borrow that a negative lane A leaves in lane B. It then rounds, shifts out the coefficient fraction and saturates each lane to a UINT8 pixel, and delivers the pixel pair on a valid/ready stream to the bicubic output stage.

---
 rtl/bicubic_pkg.sv | 20 ++
 rtl/simd_lane_round_sat.sv | 60 ++++++
 rtl/dsp_simd2x_unpack_uint8.sv | 102 ++++++++++
 3 files changed

// File: rtl/bicubic_pkg.sv
// Shared constants and pixel types for the bicubic scaler datapath.
//   DSP_P_WIDTH     : width of a DSP48 P output word
//   SIMD_LO_WIDTH   : bit position of lane B in a 2x SIMD packed P word
//   PIXEL_WIDTH     : output pixel width (UINT8)
//   COEFF_FRAC_BITS : fraction bits carried by the interpolation coefficients
package bicubic_pkg;

   localparam int DSP_P_WIDTH     = 48;
   localparam int SIMD_LO_WIDTH   = 18;
   localparam int PIXEL_WIDTH     = 8;
   localparam int COEFF_FRAC_BITS = 7;

   typedef logic [PIXEL_WIDTH-1:0] pixel_t;

   typedef struct packed {
      pixel_t b;
      pixel_t a;
   } pixel_pair_t;

endpackage

// File: rtl/simd_lane_round_sat.sv
// One lane of the SIMD unpacker: rounds away the coefficient fraction
// (stage 2 register) and clamps to a UINT8 pixel with a saturation flag
// (stage 3 register). Both registers load only when advance is high.
//   clk, aresetn : clock, asynchronous active-low reset
//   advance      : pipeline move enable shared with the whole block
//   sum          : signed lane sum from the split stage
//   pixel, sat   : clamped pixel and "result was clamped" flag
module simd_lane_round_sat
   import bicubic_pkg::*;
#(
   parameter int SUM_WIDTH = 20,
   parameter int FRAC_BITS = 7
) (
   input  logic                        clk,
   input  logic                        aresetn,
   input  logic                        advance,
   input  logic signed [SUM_WIDTH-1:0] sum,
   output pixel_t                      pixel,
   output logic                        sat
);

   // One extra bit of headroom so adding the rounding half never overflows.
   localparam int RW = SUM_WIDTH + 1;
   localparam logic signed [RW-1:0] HALF    = signed'(RW'(1) << (FRAC_BITS - 1));
   localparam logic signed [RW-1:0] PIX_MAX = RW'((1 << PIXEL_WIDTH) - 1);

   logic signed [RW-1:0] sum_ext;
   logic signed [RW-1:0] rnd_c;
   logic signed [RW-1:0] rnd_q;
   pixel_t               pix_c;
   logic                 sat_c;

   assign sum_ext = RW'(sum);
   assign rnd_c   = (sum_ext + HALF) >>> FRAC_BITS;

   always_comb begin
      pix_c = rnd_q[PIXEL_WIDTH-1:0];
      sat_c = 1'b0;
      if (rnd_q[RW-1]) begin
         pix_c = '0;
         sat_c = 1'b1;
      end else if (rnd_q > PIX_MAX) begin
         pix_c = '1;
         sat_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rnd_q <= '0;
         pixel <= '0;
         sat   <= 1'b0;
      end else if (advance) begin
         rnd_q <= rnd_c;
         pixel <= pix_c;
         sat   <= sat_c;
      end
   end

endmodule

// File: rtl/dsp_simd2x_unpack_uint8.sv
// Consumer end of the 2x INT9xUINT8 SIMD DSP packing scheme. Splits the
// packed P word into lane A (low) and lane B (high) sums, undoes the borrow
// a negative lane A leaves in lane B, then rounds, shifts and saturates each
// lane to a UINT8 pixel. Three-stage pipeline with a valid/ready stream.
//   clk, aresetn         : clock, asynchronous active-low reset
//   clken                : global pipeline enable (0 freezes everything)
//   din, din_valid       : packed P word in
//   din_ready            : word accepted this cycle
//   dout_a, dout_b       : lane A / lane B pixels
//   sat_a, sat_b         : lane was clamped
//   dout_valid, dout_ready : output handshake
module dsp_simd2x_unpack_uint8
   import bicubic_pkg::*;
#(
   parameter int LO_WIDTH  = SIMD_LO_WIDTH,
   parameter int SUM_WIDTH = 20,
   parameter int FRAC_BITS = COEFF_FRAC_BITS
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   clken,
   input  logic [DSP_P_WIDTH-1:0] din,
   input  logic                   din_valid,
   output logic                   din_ready,
   output logic [PIXEL_WIDTH-1:0] dout_a,
   output logic [PIXEL_WIDTH-1:0] dout_b,
   output logic                   sat_a,
   output logic                   sat_b,
   output logic                   dout_valid,
   input  logic                   dout_ready
);

   logic advance;
   logic s1_valid;
   logic s2_valid;

   logic signed [LO_WIDTH-1:0]  lo_raw;
   logic signed [SUM_WIDTH-2:0] hi_raw;
   logic signed [SUM_WIDTH-1:0] lo_c;
   logic signed [SUM_WIDTH-1:0] hi_c;
   logic signed [SUM_WIDTH-1:0] lo_q;
   logic signed [SUM_WIDTH-1:0] hi_q;
   logic                        unused_din_hi;
   pixel_pair_t                 pair;

   // Every stage moves together; a full output slot blocks the whole pipe.
   assign advance   = clken && (!dout_valid || dout_ready);
   assign din_ready = advance;

   assign lo_raw = din[LO_WIDTH-1:0];
   assign hi_raw = din[LO_WIDTH+SUM_WIDTH-2:LO_WIDTH];
   assign lo_c   = SUM_WIDTH'(lo_raw);
   // A negative lane A borrowed one from lane B when the products were
   // summed into the shared word; its sign bit is exactly that borrow.
   assign hi_c   = SUM_WIDTH'(hi_raw) + signed'({{(SUM_WIDTH-1){1'b0}}, din[LO_WIDTH-1]});

   assign unused_din_hi = ^din[DSP_P_WIDTH-1:LO_WIDTH+SUM_WIDTH-1];

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         dout_valid <= 1'b0;
         lo_q       <= '0;
         hi_q       <= '0;
      end else if (advance) begin
         s1_valid   <= din_valid;
         s2_valid   <= s1_valid;
         dout_valid <= s2_valid;
         lo_q       <= lo_c;
         hi_q       <= hi_c;
      end
   end

   simd_lane_round_sat #(
      .SUM_WIDTH (SUM_WIDTH),
      .FRAC_BITS (FRAC_BITS)
   ) u_lane_a (
      .clk     (clk),
      .aresetn (aresetn),
      .advance (advance),
      .sum     (lo_q),
      .pixel   (pair.a),
      .sat     (sat_a)
   );

   simd_lane_round_sat #(
      .SUM_WIDTH (SUM_WIDTH),
      .FRAC_BITS (FRAC_BITS)
   ) u_lane_b (
      .clk     (clk),
      .aresetn (aresetn),
      .advance (advance),
      .sum     (hi_q),
      .pixel   (pair.b),
      .sat     (sat_b)
   );

   assign dout_a = pair.a;
   assign dout_b = pair.b;

endmodule
